// File: rtl/resp_tx_scheduler_if.sv
// Result-source / UART-TX bundle for the response scheduler.
// master = datapath + UART side, slave = scheduler.
interface resp_tx_scheduler_if #(
    parameter int DW = 8
);
    logic [2*DW-1:0] ALU_OUT;
    logic            OUT_VALID;
    logic [DW-1:0]   RdData;
    logic            RdData_Valid;
    logic            Busy;
    logic [DW-1:0]   TX_P_DATA;
    logic            TX_D_VLD;
    logic            clk_div_en;
    logic            fifo_full;
    logic [7:0]      drop_cnt;

    modport master (
        output ALU_OUT, OUT_VALID, RdData, RdData_Valid, Busy,
        input  TX_P_DATA, TX_D_VLD, clk_div_en, fifo_full, drop_cnt
    );

    modport slave (
        input  ALU_OUT, OUT_VALID, RdData, RdData_Valid, Busy,
        output TX_P_DATA, TX_D_VLD, clk_div_en, fifo_full, drop_cnt
    );
endinterface

// File: rtl/resp_tx_scheduler.sv
// Response scheduler: queues RdData / ALU bytes in a small FIFO and
// sequences them to the UART with a level valid / Busy handshake.
module resp_tx_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input logic CLK,
    input logic RST,
    resp_tx_scheduler_if.slave bus
);
    localparam int ALU_WIDTH = 2 * DATA_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_DONE
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q, alu_base;
    logic [CW-1:0] occ_q, free, free_after;
    logic          rd_grant, alu_grant, rd_drop, alu_drop, pop;
    logic [1:0]    drop_inc;
    logic [8:0]    drop_sum;
    logic [7:0]    drop_q;
    logic [DATA_WIDTH-1:0] tx_data_q;
    logic          tx_vld_q;
    logic [ALU_WIDTH-1:0]  alu_word;

    // free space is taken at cycle start; a same-cycle pop does not help
    assign free       = DEPTH_C - occ_q;
    assign rd_grant   = bus.RdData_Valid && (free != '0);
    assign free_after = free - CW'(rd_grant);
    assign alu_grant  = bus.OUT_VALID && (free_after >= CW'(2));
    assign rd_drop    = bus.RdData_Valid && !rd_grant;
    assign alu_drop   = bus.OUT_VALID && !alu_grant;
    assign drop_inc   = {1'b0, rd_drop} + {1'b0, alu_drop};
    assign drop_sum   = {1'b0, drop_q} + 9'(drop_inc);
    assign alu_base   = rd_grant ? wptr_q + AW'(1) : wptr_q;
    assign alu_word   = bus.ALU_OUT;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (occ_q != '0 && !bus.Busy) begin
                    pop     = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.Busy) state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (!bus.Busy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK) begin
        if (rd_grant) mem[wptr_q] <= bus.RdData;
        if (alu_grant) begin
            mem[alu_base]          <= alu_word[DATA_WIDTH-1:0];
            mem[alu_base + AW'(1)] <= alu_word[ALU_WIDTH-1:DATA_WIDTH];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_q + AW'(rd_grant) + (alu_grant ? AW'(2) : AW'(0));
            rptr_q <= rptr_q + AW'(pop);
            occ_q  <= occ_q + CW'(rd_grant)
                    + (alu_grant ? CW'(2) : CW'(0)) - CW'(pop);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            drop_q <= '0;
        end else if (drop_sum[8]) begin
            drop_q <= 8'hFF;
        end else begin
            drop_q <= drop_sum[7:0];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tx_data_q <= '0;
            tx_vld_q  <= 1'b0;
        end else begin
            tx_vld_q <= (state_d == SEND);
            if (pop) tx_data_q <= mem[rptr_q];
        end
    end

    assign bus.TX_P_DATA  = tx_data_q;
    assign bus.TX_D_VLD   = tx_vld_q;
    assign bus.clk_div_en = !RST;
    assign bus.fifo_full  = (occ_q == DEPTH_C);
    assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_resp_tx_scheduler.sv
// Directed bench for resp_tx_scheduler: handshake, ordering, drops,
// saturation and mid-frame reset.
module tb_resp_tx_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    resp_tx_scheduler_if #(.DW(8)) bus ();

    resp_tx_scheduler #(.DATA_WIDTH(8), .DEPTH(4)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // UART model: wait for valid, check byte, acknowledge with Busy pulse
    task automatic expect_byte(input string tag, input logic [7:0] exp);
        int w = 0;
        while (!bus.TX_D_VLD && w < 12) begin
            tick(1);
            w++;
        end
        check({tag, "_vld"}, 16'(bus.TX_D_VLD), 16'd1);
        check({tag, "_data"}, 16'(bus.TX_P_DATA), 16'(exp));
        tick(2);
        check({tag, "_hold"}, {7'd0, bus.TX_D_VLD, bus.TX_P_DATA},
              {7'd0, 1'b1, exp});
        bus.Busy = 1'b1;
        tick(1);
        check({tag, "_vld_drop"}, 16'(bus.TX_D_VLD), 16'd0);
        tick(3);
        bus.Busy = 1'b0;
        tick(1);
        check({tag, "_idle_gap"}, 16'(bus.TX_D_VLD), 16'd0);
    endtask

    initial begin
        bus.ALU_OUT      = '0;
        bus.OUT_VALID    = 1'b0;
        bus.RdData       = '0;
        bus.RdData_Valid = 1'b0;
        bus.Busy         = 1'b0;
        tick(2);
        check("rst_vld", 16'(bus.TX_D_VLD), 16'd0);
        check("rst_data", 16'(bus.TX_P_DATA), 16'd0);
        check("rst_div", 16'(bus.clk_div_en), 16'd0);
        check("rst_full", 16'(bus.fifo_full), 16'd0);
        check("rst_drop", 16'(bus.drop_cnt), 16'd0);
        rst = 1'b0;
        #1;
        check("div_on", 16'(bus.clk_div_en), 16'd1);

        // single RdData byte, first-transaction latency
        bus.RdData = 8'hA5;
        bus.RdData_Valid = 1'b1;
        tick(1);
        bus.RdData_Valid = 1'b0;
        check("a5_not_yet", 16'(bus.TX_D_VLD), 16'd0);
        tick(1);
        check("a5_vld", 16'(bus.TX_D_VLD), 16'd1);
        check("a5_data", 16'(bus.TX_P_DATA), 16'h00A5);
        tick(4);
        check("a5_hold", 16'(bus.TX_D_VLD), 16'd1);
        bus.Busy = 1'b1;
        tick(1);
        check("a5_drop_vld", 16'(bus.TX_D_VLD), 16'd0);
        check("a5_data_keep", 16'(bus.TX_P_DATA), 16'h00A5);
        tick(3);
        bus.Busy = 1'b0;
        tick(2);
        check("a5_done", 16'(bus.TX_D_VLD), 16'd0);
        check("a5_dropcnt", 16'(bus.drop_cnt), 16'd0);

        // ALU word goes out low byte first
        bus.ALU_OUT = 16'h1234;
        bus.OUT_VALID = 1'b1;
        tick(1);
        bus.OUT_VALID = 1'b0;
        expect_byte("alu_lo", 8'h34);
        expect_byte("alu_hi", 8'h12);

        // simultaneous sources with the UART busy elsewhere
        bus.Busy = 1'b1;
        tick(1);
        bus.RdData = 8'h55;
        bus.RdData_Valid = 1'b1;
        bus.ALU_OUT = 16'hBEEF;
        bus.OUT_VALID = 1'b1;
        tick(1);
        bus.RdData_Valid = 1'b0;
        bus.OUT_VALID = 1'b0;
        check("sim_full", 16'(bus.fifo_full), 16'd0);
        check("sim_drop", 16'(bus.drop_cnt), 16'd0);
        check("sim_blocked", 16'(bus.TX_D_VLD), 16'd0);
        bus.ALU_OUT = 16'h1111;
        bus.OUT_VALID = 1'b1;
        tick(1);
        bus.OUT_VALID = 1'b0;
        check("alu_drop1", 16'(bus.drop_cnt), 16'd1);
        check("alu_drop_full", 16'(bus.fifo_full), 16'd0);
        bus.RdData = 8'h77;
        bus.RdData_Valid = 1'b1;
        tick(1);
        bus.RdData_Valid = 1'b0;
        check("rd_fill_full", 16'(bus.fifo_full), 16'd1);
        check("rd_fill_drop", 16'(bus.drop_cnt), 16'd1);
        bus.RdData_Valid = 1'b1;
        bus.OUT_VALID = 1'b1;
        tick(1);
        bus.RdData_Valid = 1'b0;
        check("both_drop", 16'(bus.drop_cnt), 16'd3);
        for (int i = 0; i < 300; i++) tick(1);
        bus.OUT_VALID = 1'b0;
        check("sat_255", 16'(bus.drop_cnt), 16'd255);
        bus.RdData_Valid = 1'b1;
        bus.OUT_VALID = 1'b1;
        tick(1);
        bus.RdData_Valid = 1'b0;
        bus.OUT_VALID = 1'b0;
        check("sat_hold", 16'(bus.drop_cnt), 16'd255);
        check("still_full", 16'(bus.fifo_full), 16'd1);

        // drain in arrival order
        bus.Busy = 1'b0;
        expect_byte("q0", 8'h55);
        check("drain_not_full", 16'(bus.fifo_full), 16'd0);
        expect_byte("q1", 8'hEF);
        expect_byte("q2", 8'hBE);
        expect_byte("q3", 8'h77);
        tick(3);
        check("drained", 16'(bus.TX_D_VLD), 16'd0);

        // reset in SEND with two bytes still queued
        bus.RdData = 8'h99;
        bus.RdData_Valid = 1'b1;
        bus.ALU_OUT = 16'hCAFE;
        bus.OUT_VALID = 1'b1;
        tick(1);
        bus.RdData_Valid = 1'b0;
        bus.OUT_VALID = 1'b0;
        tick(1);
        check("pre_rst_vld", 16'(bus.TX_D_VLD), 16'd1);
        check("pre_rst_data", 16'(bus.TX_P_DATA), 16'h0099);
        #2;
        rst = 1'b1;
        #1;
        check("async_vld", 16'(bus.TX_D_VLD), 16'd0);
        check("async_div", 16'(bus.clk_div_en), 16'd0);
        check("async_data", 16'(bus.TX_P_DATA), 16'd0);
        tick(2);
        rst = 1'b0;
        #1;
        check("post_div", 16'(bus.clk_div_en), 16'd1);
        check("post_full", 16'(bus.fifo_full), 16'd0);
        check("post_drop", 16'(bus.drop_cnt), 16'd0);
        tick(6);
        check("no_stale_vld", 16'(bus.TX_D_VLD), 16'd0);
        check("no_stale_data", 16'(bus.TX_P_DATA), 16'd0);
        check("post_div_run", 16'(bus.clk_div_en), 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
